// File: rtl/xp1_pkg.sv
// Shared widths, MISR defaults and the MISR step function for the 5xp1 result path.
package xp1_pkg;
  localparam int XP1_IN_W  = 7;
  localparam int XP1_OUT_W = 10;
  localparam int XP1_SIG_W = 16;
  localparam logic [XP1_SIG_W-1:0] XP1_SIG_POLY = 16'h1021;
  localparam logic [XP1_SIG_W-1:0] XP1_SIG_SEED = 16'hFFFF;

  // One MISR step: shift left, fold the polynomial in when the MSB falls out, then mix in the word.
  function automatic logic [XP1_SIG_W-1:0] misr_next(input logic [XP1_SIG_W-1:0] s,
                                                     input logic [XP1_OUT_W-1:0] d,
                                                     input logic [XP1_SIG_W-1:0] poly);
    logic [XP1_SIG_W-1:0] t;
    t = {s[XP1_SIG_W-2:0], 1'b0};
    if (s[XP1_SIG_W-1]) t = t ^ poly;
    return t ^ {{(XP1_SIG_W-XP1_OUT_W){1'b0}}, d};
  endfunction
endpackage

// File: rtl/xp1_misr.sv
// Multiple-input signature register compacting every accepted result word.
module xp1_misr
  import xp1_pkg::*;
#(
  parameter logic [XP1_SIG_W-1:0] POLY = XP1_SIG_POLY,
  parameter logic [XP1_SIG_W-1:0] SEED = XP1_SIG_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic [XP1_OUT_W-1:0] d,
  output logic [XP1_SIG_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sig <= SEED;
    else if (clear) sig <= SEED;
    else if (en)    sig <= misr_next(sig, d, POLY);
  end

endmodule

// File: rtl/xp1_result_fifo.sv
// Result FIFO for the 5xp1 core with a running MISR signature of every word pushed.
module xp1_result_fifo
  import xp1_pkg::*;
#(
  parameter int                   DEPTH    = 4,
  parameter logic [XP1_SIG_W-1:0] SIG_POLY = XP1_SIG_POLY,
  parameter logic [XP1_SIG_W-1:0] SIG_SEED = XP1_SIG_SEED
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [XP1_OUT_W-1:0]       in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [XP1_OUT_W-1:0]       out_data,
  input  logic                       out_ready,
  output logic [XP1_SIG_W-1:0]       sig,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XP1_OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push;
  logic                 pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !clear;
  assign pop       = out_valid && out_ready && !clear;

  // Gated so the output reads zero while empty or in reset, since storage is never reset.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  xp1_misr #(
    .POLY (SIG_POLY),
    .SEED (SIG_SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (push),
    .d     (in_data),
    .sig   (sig)
  );

endmodule

// File: tb/tb_xp1_result_fifo.sv
// Bench for xp1_result_fifo: directed vector table, stream and reset sequences, random scoreboard run.
module tb_xp1_result_fifo;
  localparam int DEPTH = 4;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [9:0]  out_data;
  logic        out_ready = 1'b0;
  logic [15:0] sig;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [9:0]  mq[$];
  logic [15:0] msig = SEED;

  always #5 clk = ~clk;

  xp1_result_fifo #(.DEPTH(DEPTH), .SIG_POLY(POLY), .SIG_SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sig       (sig),
    .count     (count)
  );

  typedef struct {
    logic        clr;
    logic        iv;
    logic [9:0]  id;
    logic        ordy;
    int          cnt;
    logic        ir;
    logic        ov;
    logic        chk_sig;
    logic [15:0] sig;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [9:0] d);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ POLY;
    return t ^ {6'b0, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle, advances the model, checks at the following negedge.
  task automatic step(input logic clr, input logic iv, input logic [9:0] id, input logic ordy);
    logic push_m, pop_m;
    logic [9:0] exp_d;
    clear = clr; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    push_m = iv && (mq.size() != DEPTH) && !clr;
    pop_m  = (mq.size() != 0) && ordy && !clr;
    if (pop_m) begin
      exp_d = mq[0];
      chk("pop_data", {22'b0, out_data}, {22'b0, exp_d});
    end
    @(posedge clk);
    if (clr) begin
      mq.delete();
      msig = SEED;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back(id);
        msig = ref_misr(msig, id);
      end
    end
    @(negedge clk);
    chk("count", {29'b0, count}, mq.size());
    chk("sig", {16'b0, sig}, {16'b0, msig});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() != DEPTH});
  endtask

  initial begin
    //            clr   iv    id      ordy  cnt ir    ov    chk   sig
    vecs[0]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1, 1'b1, 1'b1, 1'b1, 16'hEFDF};
    vecs[1]  = '{1'b0, 1'b0, 10'h000, 1'b1, 0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 10'h001, 1'b0, 1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 10'h002, 1'b0, 2, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 10'h003, 1'b0, 3, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 10'h004, 1'b0, 4, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 10'h005, 1'b0, 4, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 10'h006, 1'b1, 3, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b1, 10'h007, 1'b1, 0, 1'b1, 1'b0, 1'b1, 16'hFFFF};
    vecs[9]  = '{1'b0, 1'b1, 10'h3FF, 1'b0, 1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 10'h155, 1'b1, 1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 10'h000, 1'b1, 0, 1'b1, 1'b0, 1'b0, 16'h0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_sig", {16'b0, sig}, {16'b0, SEED});
    chk("rst_out_data", {22'b0, out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].clr, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d_count", i), {29'b0, count}, vecs[i].cnt);
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].ir});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ov});
      if (vecs[i].chk_sig) chk($sformatf("vec%0d_sig", i), {16'b0, sig}, {16'b0, vecs[i].sig});
      if (i == 0) chk("vec0_out_data", {22'b0, out_data}, 32'h000);
    end

    // Stream of 16 words, one every other cycle, always drained
    for (int w = 0; w < 16; w++) begin
      step(1'b0, 1'b1, 10'(w * 37 + 5), 1'b1);
      chk("stream_cnt_hi", {29'b0, count}, 32'd1);
      step(1'b0, 1'b0, 10'h000, 1'b1);
      chk("stream_cnt_lo", {29'b0, count}, 32'd0);
    end

    // Asynchronous reset with two words buffered
    step(1'b0, 1'b1, 10'h2AA, 1'b0);
    step(1'b0, 1'b1, 10'h0F0, 1'b0);
    chk("pre_arst_count", {29'b0, count}, 32'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", {29'b0, count}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_sig", {16'b0, sig}, {16'b0, SEED});
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    msig = SEED;

    // Random push/pop/clear against the model
    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(63) == 0), $urandom_range(1), 10'($urandom), $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
